rtc_access_scheduler: RTL and testbench

- Sequences and arbitrates the shared RTC parallel bus (AD/CS/RD/WR/data) between two step-indexed sequence ROMs:
  - the write/configuration sequencer (addr 1..93, signals completion with Listo_es);
  - the read/refresh sequencer (signals completion with listo_lee).
- Holds the step address for each ROM and advances it at a programmable rate.
- Grants the bus to one sequence at a time, with write having priority over read.
- Issues periodic refresh reads and reports completion and timeout status.

---
 rtl/rtc_access_scheduler.sv | 166 ++++++++++++++++
 tb/tb_rtc_access_scheduler.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_access_scheduler.sv
// Arbitrates the shared RTC parallel bus between the write/config and read/refresh
// sequence ROMs: steps their addresses, issues periodic refresh reads, reports status.
module rtc_access_scheduler #(
    parameter int TICK_DIV    = 4,
    parameter int WR_LAST     = 93,
    parameter int RD_LAST     = 40,
    parameter int REFRESH_CYC = 100000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req_wr,
    input  logic       i_req_rd,
    input  logic       i_listo_es,
    input  logic       i_listo_lee,
    output logic [6:0] o_addr_es,
    output logic       o_en_es,
    output logic [6:0] o_addr_lee,
    output logic       o_en_lee,
    output logic       o_bus_sel,
    output logic       o_busy,
    output logic       o_done_wr,
    output logic       o_done_rd,
    output logic       o_err_to
);
    localparam int             TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]  TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [6:0]     WR_END   = 7'(WR_LAST);
    localparam logic [6:0]     RD_END   = 7'(RD_LAST);
    localparam logic [31:0]    REF_MAX  = 32'(REFRESH_CYC - 1);

    typedef enum logic [1:0] {IDLE, WR_RUN, RD_RUN, GAP} state_t;

    state_t         r_state, w_state;
    logic [TW-1:0]  r_tick, w_tick;
    logic [31:0]    r_refresh, w_refresh;
    logic           r_pend_wr, w_pend_wr, r_pend_rd, w_pend_rd;
    logic [6:0]     r_addr_es, w_addr_es, r_addr_lee, w_addr_lee;
    logic           r_en_es, w_en_es, r_en_lee, w_en_lee;
    logic           r_bus_sel, w_bus_sel, r_busy, w_busy;
    logic           r_done_wr, w_done_wr, r_done_rd, w_done_rd;
    logic           r_err_to, w_err_to;
    logic           w_grant_wr, w_grant_rd, w_step_end, w_ref_wrap;

    always_comb begin
        w_state    = r_state;
        w_tick     = r_tick;
        w_addr_es  = r_addr_es;
        w_en_es    = r_en_es;
        w_addr_lee = r_addr_lee;
        w_en_lee   = r_en_lee;
        w_bus_sel  = r_bus_sel;
        w_done_wr  = 1'b0;
        w_done_rd  = 1'b0;
        w_err_to   = r_err_to;
        w_grant_wr = 1'b0;
        w_grant_rd = 1'b0;
        w_step_end = (r_tick == TICK_MAX);
        w_ref_wrap = (r_refresh == REF_MAX);

        case (r_state)
            IDLE: begin
                if (r_pend_wr) begin
                    w_state    = WR_RUN;
                    w_grant_wr = 1'b1;
                    w_addr_es  = 7'd1;
                    w_en_es    = 1'b1;
                    w_tick     = '0;
                    w_bus_sel  = 1'b1;
                end else if (r_pend_rd) begin
                    w_state    = RD_RUN;
                    w_grant_rd = 1'b1;
                    w_addr_lee = 7'd1;
                    w_en_lee   = 1'b1;
                    w_tick     = '0;
                    w_bus_sel  = 1'b0;
                end
            end
            // listo is judged at the end of each step, so the last step always
            // gets its full TICK_DIV cycles on the bus before the sequence closes.
            WR_RUN: begin
                w_tick = w_step_end ? '0 : r_tick + TW'(1);
                if (w_step_end) begin
                    if (i_listo_es || (r_addr_es == WR_END)) begin
                        w_state   = GAP;
                        w_en_es   = 1'b0;
                        w_addr_es = 7'd0;
                        w_done_wr = i_listo_es;
                        w_err_to  = r_err_to | ~i_listo_es;
                    end else begin
                        w_addr_es = r_addr_es + 7'd1;
                    end
                end
            end
            RD_RUN: begin
                w_tick = w_step_end ? '0 : r_tick + TW'(1);
                if (w_step_end) begin
                    if (i_listo_lee || (r_addr_lee == RD_END)) begin
                        w_state    = GAP;
                        w_en_lee   = 1'b0;
                        w_addr_lee = 7'd0;
                        w_done_rd  = i_listo_lee;
                        w_err_to   = r_err_to | ~i_listo_lee;
                    end else begin
                        w_addr_lee = r_addr_lee + 7'd1;
                    end
                end
            end
            GAP: begin
                w_tick = w_step_end ? '0 : r_tick + TW'(1);
                if (w_step_end) w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase

        w_busy    = (w_state != IDLE);
        // A request in the grant cycle is a new request and stays pending.
        w_pend_wr = (r_pend_wr & ~w_grant_wr) | i_req_wr;
        w_pend_rd = (r_pend_rd & ~w_grant_rd) | i_req_rd | w_ref_wrap;
        w_refresh = w_ref_wrap ? 32'd0 : r_refresh + 32'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_tick     <= '0;
            r_refresh  <= 32'd0;
            r_pend_wr  <= 1'b0;
            r_pend_rd  <= 1'b0;
            r_addr_es  <= 7'd0;
            r_en_es    <= 1'b0;
            r_addr_lee <= 7'd0;
            r_en_lee   <= 1'b0;
            r_bus_sel  <= 1'b0;
            r_busy     <= 1'b0;
            r_done_wr  <= 1'b0;
            r_done_rd  <= 1'b0;
            r_err_to   <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_tick     <= w_tick;
            r_refresh  <= w_refresh;
            r_pend_wr  <= w_pend_wr;
            r_pend_rd  <= w_pend_rd;
            r_addr_es  <= w_addr_es;
            r_en_es    <= w_en_es;
            r_addr_lee <= w_addr_lee;
            r_en_lee   <= w_en_lee;
            r_bus_sel  <= w_bus_sel;
            r_busy     <= w_busy;
            r_done_wr  <= w_done_wr;
            r_done_rd  <= w_done_rd;
            r_err_to   <= w_err_to;
        end
    end

    assign o_addr_es  = r_addr_es;
    assign o_en_es    = r_en_es;
    assign o_addr_lee = r_addr_lee;
    assign o_en_lee   = r_en_lee;
    assign o_bus_sel  = r_bus_sel;
    assign o_busy     = r_busy;
    assign o_done_wr  = r_done_wr;
    assign o_done_rd  = r_done_rd;
    assign o_err_to   = r_err_to;

endmodule

// File: tb/tb_rtc_access_scheduler.sv
// Bench for rtc_access_scheduler: three instances (A: TICK_DIV=2, B: fast refresh,
// C: short read ROM that never finishes) checked against a timeline model.
module tb_rtc_access_scheduler;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [NI];
    logic       req_wr [NI];
    logic       req_rd [NI];
    logic       listo_es [NI];
    logic       listo_lee [NI];
    logic [6:0] addr_es [NI];
    logic       en_es [NI];
    logic [6:0] addr_lee [NI];
    logic       en_lee [NI];
    logic       bus_sel [NI];
    logic       busy [NI];
    logic       done_wr [NI];
    logic       done_rd [NI];
    logic       err_to [NI];

    int n_vec = 0;
    int n_err = 0;

    function automatic int p_td(input int i);  return (i == 0) ? 2 : 1;          endfunction
    function automatic int p_wrl(input int i); return 93;                         endfunction
    function automatic int p_rdl(input int i); return (i == 2) ? 5 : 40;          endfunction
    function automatic int p_ref(input int i); return (i == 1) ? 50 : 100000;     endfunction
    function automatic bit p_lok(input int i); return (i != 2);                   endfunction

    rtc_access_scheduler #(.TICK_DIV(2), .WR_LAST(93), .RD_LAST(40), .REFRESH_CYC(100000)) u_a (
        .i_clk(clk), .i_rst(rst[0]), .i_req_wr(req_wr[0]), .i_req_rd(req_rd[0]),
        .i_listo_es(listo_es[0]), .i_listo_lee(listo_lee[0]),
        .o_addr_es(addr_es[0]), .o_en_es(en_es[0]), .o_addr_lee(addr_lee[0]), .o_en_lee(en_lee[0]),
        .o_bus_sel(bus_sel[0]), .o_busy(busy[0]), .o_done_wr(done_wr[0]), .o_done_rd(done_rd[0]),
        .o_err_to(err_to[0]));

    rtc_access_scheduler #(.TICK_DIV(1), .WR_LAST(93), .RD_LAST(40), .REFRESH_CYC(50)) u_b (
        .i_clk(clk), .i_rst(rst[1]), .i_req_wr(req_wr[1]), .i_req_rd(req_rd[1]),
        .i_listo_es(listo_es[1]), .i_listo_lee(listo_lee[1]),
        .o_addr_es(addr_es[1]), .o_en_es(en_es[1]), .o_addr_lee(addr_lee[1]), .o_en_lee(en_lee[1]),
        .o_bus_sel(bus_sel[1]), .o_busy(busy[1]), .o_done_wr(done_wr[1]), .o_done_rd(done_rd[1]),
        .o_err_to(err_to[1]));

    rtc_access_scheduler #(.TICK_DIV(1), .WR_LAST(93), .RD_LAST(5), .REFRESH_CYC(100000)) u_c (
        .i_clk(clk), .i_rst(rst[2]), .i_req_wr(req_wr[2]), .i_req_rd(req_rd[2]),
        .i_listo_es(listo_es[2]), .i_listo_lee(listo_lee[2]),
        .o_addr_es(addr_es[2]), .o_en_es(en_es[2]), .o_addr_lee(addr_lee[2]), .o_en_lee(en_lee[2]),
        .o_bus_sel(bus_sel[2]), .o_busy(busy[2]), .o_done_wr(done_wr[2]), .o_done_rd(done_rd[2]),
        .o_err_to(err_to[2]));

    // ROM end flags: combinational on the last step; instance C's read ROM never finishes.
    always_comb begin
        for (int i = 0; i < NI; i++) begin
            listo_es[i]  = en_es[i] && (addr_es[i] == 7'(p_wrl(i)));
            listo_lee[i] = p_lok(i) && en_lee[i] && (addr_lee[i] == 7'(p_rdl(i)));
        end
    end

    // Timeline model: phase 0 idle, 1 running (j cycles since grant), 2 gap (g cycles).
    int m_ph [NI];
    int m_j  [NI];
    int m_g  [NI];
    int m_ref [NI];
    bit m_kwr [NI];
    bit m_pwr [NI];
    bit m_prd [NI];
    bit e_bus [NI];
    bit e_dwr [NI];
    bit e_drd [NI];
    bit e_err [NI];
    bit m_wrap;

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst[i]) begin
                m_ph[i] = 0; m_j[i] = 0; m_g[i] = 0; m_ref[i] = 0;
                m_kwr[i] = 0; m_pwr[i] = 0; m_prd[i] = 0;
                e_bus[i] = 0; e_dwr[i] = 0; e_drd[i] = 0; e_err[i] = 0;
            end else begin
                m_wrap   = (m_ref[i] == p_ref(i) - 1);
                m_ref[i] = m_wrap ? 0 : m_ref[i] + 1;
                e_dwr[i] = 0;
                e_drd[i] = 0;
                if (m_ph[i] == 0) begin
                    if (m_pwr[i]) begin
                        m_ph[i] = 1; m_kwr[i] = 1; m_j[i] = 0; m_pwr[i] = 0; e_bus[i] = 1;
                    end else if (m_prd[i]) begin
                        m_ph[i] = 1; m_kwr[i] = 0; m_j[i] = 0; m_prd[i] = 0; e_bus[i] = 0;
                    end
                end else if (m_ph[i] == 1) begin
                    m_j[i] = m_j[i] + 1;
                    if (m_j[i] == (m_kwr[i] ? p_wrl(i) : p_rdl(i)) * p_td(i)) begin
                        m_ph[i] = 2; m_g[i] = 0;
                        if (m_kwr[i]) e_dwr[i] = 1;
                        else if (p_lok(i)) e_drd[i] = 1;
                        else e_err[i] = 1;
                    end
                end else begin
                    m_g[i] = m_g[i] + 1;
                    if (m_g[i] == p_td(i)) m_ph[i] = 0;
                end
                m_pwr[i] = m_pwr[i] | req_wr[i];
                m_prd[i] = m_prd[i] | req_rd[i] | m_wrap;
            end
        end
    end

    function automatic logic [20:0] expv(input int i);
        logic rw, rr;
        logic [6:0] a;
        rw = (m_ph[i] == 1) && m_kwr[i];
        rr = (m_ph[i] == 1) && !m_kwr[i];
        a  = 7'(1 + m_j[i] / p_td(i));
        return {rw ? a : 7'd0, rw, rr ? a : 7'd0, rr, e_bus[i], (m_ph[i] != 0),
                e_dwr[i], e_drd[i], e_err[i]};
    endfunction

    function automatic logic [20:0] obs(input int i);
        return {addr_es[i], en_es[i], addr_lee[i], en_lee[i], bus_sel[i], busy[i],
                done_wr[i], done_rd[i], err_to[i]};
    endfunction

    task automatic pulse_wr(input int i);
        @(negedge clk); req_wr[i] = 1'b1;
        @(negedge clk); req_wr[i] = 1'b0;
    endtask

    task automatic pulse_rd(input int i);
        @(negedge clk); req_rd[i] = 1'b1;
        @(negedge clk); req_rd[i] = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            n_vec++;
            if (obs(i) !== 21'd0) begin
                n_err++; $display("FAIL reset_hold inst%0d: got %h want 0", i, obs(i));
            end
            rst[i] = 1'b0;
        end
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            n_vec++;
            if (obs(i) !== 21'd0) begin
                n_err++; $display("FAIL reset_idle inst%0d: got %h want 0", i, obs(i));
            end
        end
    endtask

    task automatic test_write_seq();
        int en_cnt = 0, dn = 0, hold1 = 0, hold93 = 0, sel_bad = 0;
        pulse_wr(0);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            n_vec++;
            if (obs(0) !== expv(0)) begin
                n_err++; $display("FAIL write_seq cyc%0d: got %h want %h", c, obs(0), expv(0));
            end
            if (en_es[0]) en_cnt++;
            if (en_es[0] && !bus_sel[0]) sel_bad++;
            if (done_wr[0]) dn++;
            if (en_es[0] && addr_es[0] == 7'd1) hold1++;
            if (en_es[0] && addr_es[0] == 7'd93) hold93++;
        end
        n_vec += 6;
        if (en_cnt != 186) begin n_err++; $display("FAIL write_len: got %0d want 186", en_cnt); end
        if (dn != 1) begin n_err++; $display("FAIL write_done_count: got %0d want 1", dn); end
        if (hold1 != 2) begin n_err++; $display("FAIL write_hold_first: got %0d want 2", hold1); end
        if (hold93 != 2) begin n_err++; $display("FAIL write_hold_last: got %0d want 2", hold93); end
        if (sel_bad != 0) begin n_err++; $display("FAIL write_bus_sel: got %0d low cycles want 0", sel_bad); end
        if (err_to[0] !== 1'b0) begin n_err++; $display("FAIL write_err: got %b want 0", err_to[0]); end
    endtask

    task automatic test_wr_rd_same();
        int t_dwr = -1, t_drd = -1, t_rs = -1, both = 0;
        logic [7:0] rs_info = 8'h00;
        @(negedge clk); req_wr[0] = 1'b1; req_rd[0] = 1'b1;
        @(negedge clk); req_wr[0] = 1'b0; req_rd[0] = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            n_vec++;
            if (obs(0) !== expv(0)) begin
                n_err++; $display("FAIL wr_rd_same cyc%0d: got %h want %h", c, obs(0), expv(0));
            end
            if (en_es[0] && en_lee[0]) both++;
            if (done_wr[0] && t_dwr < 0) t_dwr = c;
            if (done_rd[0] && t_drd < 0) t_drd = c;
            if (en_lee[0] && t_rs < 0) begin t_rs = c; rs_info = {addr_lee[0], bus_sel[0]}; end
        end
        n_vec += 4;
        if (both != 0) begin n_err++; $display("FAIL wr_rd_overlap: got %0d want 0", both); end
        if (!(t_dwr >= 0 && t_drd > t_dwr)) begin
            n_err++; $display("FAIL wr_rd_order: done_wr@%0d done_rd@%0d", t_dwr, t_drd);
        end
        if (t_rs - t_dwr != 3) begin n_err++; $display("FAIL wr_rd_gap: got %0d want 3", t_rs - t_dwr); end
        if (rs_info !== {7'd1, 1'b0}) begin
            n_err++; $display("FAIL rd_start: got %h want %h", rs_info, {7'd1, 1'b0});
        end
    endtask

    task automatic test_merge();
        int starts = 0;
        logic prev = 1'b0;
        pulse_wr(0);
        for (int c = 0; c < 330; c++) begin
            @(negedge clk);
            n_vec++;
            if (obs(0) !== expv(0)) begin
                n_err++; $display("FAIL merge cyc%0d: got %h want %h", c, obs(0), expv(0));
            end
            if (en_lee[0] && !prev) starts++;
            prev = en_lee[0];
            req_rd[0] = (c == 10 || c == 50 || c == 120);
        end
        req_rd[0] = 1'b0;
        n_vec++;
        if (starts != 1) begin n_err++; $display("FAIL merge_reads: got %0d want 1", starts); end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        int dn = 0;
        pulse_wr(0);
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (done_wr[0]) dn++;
            if (addr_es[0] == 7'd40) found = 1;
        end
        n_vec++;
        if (!found) begin n_err++; $display("FAIL reset_mid_reach: got no addr 40 want addr 40"); end
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        n_vec += 2;
        if (obs(0) !== 21'd0) begin n_err++; $display("FAIL reset_mid_clear: got %h want 0", obs(0)); end
        if (dn != 0) begin n_err++; $display("FAIL reset_mid_done: got %0d want 0", dn); end
        pulse_wr(0);
        @(negedge clk);
        n_vec++;
        if ({addr_es[0], en_es[0]} !== {7'd1, 1'b1}) begin
            n_err++; $display("FAIL reset_mid_restart: got %h want %h", {addr_es[0], en_es[0]}, {7'd1, 1'b1});
        end
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            n_vec++;
            if (obs(0) !== expv(0)) begin
                n_err++; $display("FAIL reset_mid_run cyc%0d: got %h want %h", c, obs(0), expv(0));
            end
        end
    endtask

    task automatic test_refresh();
        int st[$];
        int dn = 0;
        logic prev = 1'b0;
        @(negedge clk); rst[1] = 1'b1;
        @(negedge clk); rst[1] = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            n_vec++;
            if (obs(1) !== expv(1)) begin
                n_err++; $display("FAIL refresh cyc%0d: got %h want %h", c, obs(1), expv(1));
            end
            if (en_lee[1] && !prev) st.push_back(c);
            prev = en_lee[1];
            if (done_rd[1]) dn++;
        end
        n_vec += 2;
        if (st.size() != 3) begin n_err++; $display("FAIL refresh_starts: got %0d want 3", st.size()); end
        if (dn != 3) begin n_err++; $display("FAIL refresh_dones: got %0d want 3", dn); end
        for (int k = 1; k < st.size(); k++) begin
            n_vec++;
            if (st[k] - st[k-1] != 50) begin
                n_err++; $display("FAIL refresh_period: got %0d want 50", st[k] - st[k-1]);
            end
        end
    endtask

    task automatic test_timeout();
        int dn = 0, dw = 0;
        @(negedge clk); rst[2] = 1'b1;
        @(negedge clk); rst[2] = 1'b0;
        pulse_rd(2);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_vec++;
            if (obs(2) !== expv(2)) begin
                n_err++; $display("FAIL timeout cyc%0d: got %h want %h", c, obs(2), expv(2));
            end
            if (c < 5) begin
                n_vec++;
                if ({addr_lee[2], en_lee[2]} !== {7'(c + 1), 1'b1}) begin
                    n_err++; $display("FAIL timeout_step%0d: got %h want %h", c, {addr_lee[2], en_lee[2]}, {7'(c + 1), 1'b1});
                end
            end
            if (done_rd[2]) dn++;
        end
        n_vec += 2;
        if ({en_lee[2], err_to[2]} !== 2'b01) begin
            n_err++; $display("FAIL timeout_flag: got %b want 01", {en_lee[2], err_to[2]});
        end
        if (dn != 0) begin n_err++; $display("FAIL timeout_done: got %0d want 0", dn); end
        pulse_wr(2);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            n_vec++;
            if (obs(2) !== expv(2)) begin
                n_err++; $display("FAIL timeout_wr cyc%0d: got %h want %h", c, obs(2), expv(2));
            end
            if (done_wr[2]) dw++;
        end
        n_vec += 2;
        if (dw != 1) begin n_err++; $display("FAIL timeout_wr_done: got %0d want 1", dw); end
        if (err_to[2] !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", err_to[2]); end
        @(negedge clk); rst[2] = 1'b1;
        @(negedge clk); rst[2] = 1'b0;
        n_vec++;
        if (err_to[2] !== 1'b0) begin n_err++; $display("FAIL err_clear: got %b want 0", err_to[2]); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                n_vec += 2;
                if (obs(i) !== expv(i)) begin
                    n_err++; $display("FAIL random inst%0d cyc%0d: got %h want %h", i, c, obs(i), expv(i));
                end
                if ((en_es[i] && en_lee[i]) !== 1'b0) begin
                    n_err++; $display("FAIL random_excl inst%0d cyc%0d: got both enables want one", i, c);
                end
                req_wr[i] = ($urandom_range(0, 399) == 0);
                req_rd[i] = ($urandom_range(0, 149) == 0);
            end
        end
        for (int i = 0; i < NI; i++) begin
            req_wr[i] = 1'b0;
            req_rd[i] = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1; req_wr[i] = 1'b0; req_rd[i] = 1'b0;
        end
        test_reset();
        test_write_seq();
        test_wr_rd_same();
        test_merge();
        test_reset_mid();
        test_refresh();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
